ex_muldiv_sequencer: RTL and testbench
======================================

# ex_muldiv_sequencer

Iterative multiply/divide unit and HI/LO register owner for the execute stage. Accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a 32-iteration shift-add or restoring-divide sequence, and writes HI/LO. Raises a pipeline stall whenever the in-flight operation would be observed early: a new mul/div, a HI/LO read or a HI/LO write. Sits beside the ALU in EX; results are read back through MFHI/MFLO.

## Interface
- NB_DATA, 32: operand and HI/LO width; the iteration count equals NB_DATA.

- clk  in  1  pipeline clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_halt  in  1  freezes every register, including the FSM, counter, HI and LO.
- i_start  in  1  EX holds a mul/div instruction this cycle.
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_datoA  in  NB_DATA  forwarded rs (multiplicand/dividend).
- i_datoB  in  NB_DATA  forwarded rt (multiplier/divisor).
- i_rd_hilo  in  1  EX holds MFHI/MFLO.
- i_wr_hi  in  1  MTHI.
- i_wr_lo  in  1  MTLO.
- i_wdata  in  NB_DATA  MTHI/MTLO data.
- o_busy  out  1  FSM not in IDLE.
- o_stall  out  1  hold IF/ID/EX and bubble EX/MEM.
- o_done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.

## Operation
- Reset: state IDLE, counter 0, o_hi = o_lo = 0, o_done = 0. o_busy and o_stall are 0 as a consequence.
- IDLE, i_start = 1:
  - latch the magnitudes of A and B. Signed ops take two's-complement abs; unsigned ops pass through.
  - latch the result signs: MULT sign = A[31]^B[31]; DIV quotient sign = A[31]^B[31], remainder sign = A[31].
  - load counter = NB_DATA-1, clear the 2·NB_DATA accumulator, go to RUN.
- RUN, one iteration per cycle:
  - mul: if multiplier LSB is set, add the multiplicand to the upper half; then shift the accumulator right by 1 (NB_DATA+1-bit add, carry kept).
  - div (restoring): shift {rem, quo} left by 1; trial-subtract the divisor from rem; on no borrow keep the difference and set quo LSB.
  - counter == 0 → FIX; otherwise decrement the counter.
- FIX, one cycle: apply sign correction (negate the product, quotient or remainder per the latched signs), write HI/LO, pulse o_done the following cycle, go to IDLE.
  - mul results: HI = product[63:32], LO = product[31:0].
  - div results: LO = quotient, HI = remainder.
- Division by zero (B == 0, sampled at start): skip the RUN arithmetic. Still spend the full NB_DATA+1 cycles, so latency is data-independent. Write LO = all-ones, HI = A.
- DIV 0x80000000 / 0xFFFFFFFF: result wraps; LO = 0x80000000, HI = 0.
- MTHI/MTLO in IDLE: the register updates on the next edge. If i_start is asserted in the same cycle, i_start wins and the write is dropped; the pipeline never issues both together.
- o_stall = o_busy & (i_start | i_rd_hilo | i_wr_hi | i_wr_lo), combinational.
  - i_start while busy is ignored; the stall keeps the instruction in EX until IDLE.
- i_halt = 1: nothing advances; o_stall still reflects its inputs.
- i_rst mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- Start sampled at edge E0 → RUN during cycles 1..NB_DATA → FIX in cycle NB_DATA+1.
- HI/LO valid and o_done = 1 after edge NB_DATA+2 (34 for NB_DATA = 32).
- A dependent MFHI stalls until that cycle and reads the new value with zero extra delay.
- Back-to-back mul/div: the second start is accepted in the o_done cycle; there is no dead cycle.
- MTHI/MTLO latency is one edge.

## Structure
- Shared package mips_pkg holds:
  - MULDIV op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - FSM state localparams: IDLE, RUN, FIX.
- Single module, no sub-modules; the mul and div datapaths share the accumulator and counter.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 34 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; o_done high for exactly 1 cycle.
- DIVU 100 / 7 → LO = 14, HI = 2. DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 5 / 0 → LO = 0xFFFFFFFF, HI = 5, still 34 cycles. DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- MFHI issued 1 cycle after MULTU 0xFFFFFFFF × 0xFFFFFFFF → o_stall high for 33 cycles, then HI = 0xFFFFFFFE, LO = 1.
- i_halt held for 10 cycles mid-RUN → completion delayed by exactly 10 cycles, same result.
- i_rst pulsed mid-RUN → o_busy = 0, HI = LO = 0 immediately; a following MTLO 0x1234 → LO = 0x1234 after one edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

endpackage

// File: rtl/ex_muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO; one iteration per cycle,
// fixed NB_DATA+2 cycle latency from start to visible result.
module ex_muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_halt,
  input  logic               i_start,
  input  logic [1:0]         i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  input  logic               i_rd_hilo,
  input  logic               i_wr_hi,
  input  logic               i_wr_lo,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic               o_busy,
  output logic               o_stall,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int NB_CNT = $clog2(NB_DATA);

  md_state_t state, next_state;

  logic [NB_CNT-1:0]    cnt;
  logic [2*NB_DATA-1:0] acc;
  logic [NB_DATA-1:0]   a_reg, b_reg, hi, lo;
  logic                 is_div, divz, sign_q, sign_r, done;

  logic                 op_signed, op_div;
  logic [NB_DATA-1:0]   a_abs, b_abs;
  logic [NB_DATA:0]     mul_sum, rem_sh;
  logic                 borrow;
  logic [NB_DATA-1:0]   diff;
  logic [2*NB_DATA-1:0] div_next, prod;
  logic [NB_DATA-1:0]   quo, rem, fix_hi, fix_lo;

  assign op_signed = ~i_op[0];
  assign op_div    = i_op[1];
  assign a_abs     = (op_signed && i_datoA[NB_DATA-1]) ? -i_datoA : i_datoA;
  assign b_abs     = (op_signed && i_datoB[NB_DATA-1]) ? -i_datoB : i_datoB;

  // mul: a_reg = multiplicand, b_reg = multiplier (consumed LSB first)
  assign mul_sum = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, (b_reg[0] ? a_reg : '0)};

  // div: dividend bits enter rem from a_reg's MSB since acc starts cleared
  assign rem_sh   = {acc[2*NB_DATA-1:NB_DATA], a_reg[NB_DATA-1]};
  assign borrow   = rem_sh < {1'b0, b_reg};
  assign diff     = rem_sh[NB_DATA-1:0] - b_reg;
  assign div_next = borrow ? {rem_sh[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0}
                           : {diff, acc[NB_DATA-2:0], 1'b1};

  assign prod = sign_q ? -acc : acc;
  assign quo  = sign_q ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
  assign rem  = sign_r ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];

  always_comb begin
    fix_hi = prod[2*NB_DATA-1:NB_DATA];
    fix_lo = prod[NB_DATA-1:0];
    if (is_div) begin
      if (divz) begin
        // a_reg is untouched on divide-by-zero, so re-signing it restores A
        fix_hi = sign_r ? -a_reg : a_reg;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (i_start) next_state = RUN;
      RUN:     if (cnt == '0) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else if (!i_halt) state <= next_state;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      acc    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      divz   <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done   <= 1'b0;
    end else if (!i_halt) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            a_reg  <= a_abs;
            b_reg  <= b_abs;
            acc    <= '0;
            cnt    <= NB_CNT'(NB_DATA - 1);
            is_div <= op_div;
            divz   <= op_div && (i_datoB == '0);
            sign_q <= op_signed & (i_datoA[NB_DATA-1] ^ i_datoB[NB_DATA-1]);
            sign_r <= op_signed & op_div & i_datoA[NB_DATA-1];
          end else begin
            if (i_wr_hi) hi <= i_wdata;
            if (i_wr_lo) lo <= i_wdata;
          end
        end
        RUN: begin
          if (!divz) begin
            if (is_div) begin
              acc   <= div_next;
              a_reg <= a_reg << 1;
            end else begin
              acc   <= {mul_sum, acc[NB_DATA-1:1]};
              b_reg <= b_reg >> 1;
            end
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_stall = o_busy & (i_start | i_rd_hilo | i_wr_hi | i_wr_lo);
  assign o_done  = done;
  assign o_hi    = hi;
  assign o_lo    = lo;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: results, latency, stall, halt, reset.
module tb_ex_muldiv_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_halt, i_start, i_rd_hilo, i_wr_hi, i_wr_lo;
  logic [1:0]  i_op;
  logic [31:0] i_datoA, i_datoB, i_wdata;
  logic        o_busy, o_stall, o_done;
  logic [31:0] o_hi, o_lo;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int stall_cnt;

  ex_muldiv_sequencer #(.NB_DATA(32)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_halt    (i_halt),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_datoA   (i_datoA),
    .i_datoB   (i_datoB),
    .i_rd_hilo (i_rd_hilo),
    .i_wr_hi   (i_wr_hi),
    .i_wr_lo   (i_wr_lo),
    .i_wdata   (i_wdata),
    .o_busy    (o_busy),
    .o_stall   (o_stall),
    .o_done    (o_done),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle; n counts edges from the start edge inclusive.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op    = op;
    i_datoA = a;
    i_datoB = b;
    tick();
    i_start = 1'b0;
    n = 1;
  endtask

  task automatic wait_done;
    while (!o_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(op, a, b);
    wait_done();
    check({tag, "_lat"}, 64'(n), 64'd34);
    check({tag, "_hi"}, 64'(o_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(o_lo), 64'(elo));
  endtask

  initial begin
    i_rst = 1'b1; i_halt = 1'b0; i_start = 1'b0; i_op = MD_MULT;
    i_datoA = '0; i_datoB = '0; i_rd_hilo = 1'b0; i_wr_hi = 1'b0;
    i_wr_lo = 1'b0; i_wdata = '0;
    tick();
    tick();
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    i_rst = 1'b0;
    tick();

    run_check("mult", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    check("mult_done_pulse", 64'(o_done), 64'd0);

    // back-to-back: next start issued in the done cycle
    run_check("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div_zero", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_check("div_zero_neg", MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_check("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    tick();

    // dependent MFHI right after MULTU
    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    i_rd_hilo = 1'b1;
    stall_cnt = 0;
    while (o_stall && stall_cnt < 100) begin
      stall_cnt++;
      tick();
    end
    check("mfhi_stall_cycles", 64'(stall_cnt), 64'd33);
    check("multu_hi", 64'(o_hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(o_lo), 64'd1);
    check("multu_done", 64'(o_done), 64'd1);
    i_rd_hilo = 1'b0;
    tick();

    // halt for 10 cycles in RUN
    start_op(MD_MULT, 32'h0001_2345, 32'h0000_0100);
    repeat (5) begin tick(); n++; end
    i_halt = 1'b1;
    i_rd_hilo = 1'b1;
    #1;
    check("halt_stall", 64'(o_stall), 64'd1);
    repeat (10) begin tick(); n++; end
    check("halt_busy", 64'(o_busy), 64'd1);
    i_halt = 1'b0;
    i_rd_hilo = 1'b0;
    wait_done();
    check("halt_lat", 64'(n), 64'd44);
    check("halt_hi", 64'(o_hi), 64'd0);
    check("halt_lo", 64'(o_lo), 64'h0123_4500);
    tick();

    // MTHI in the same cycle as start is dropped
    i_wr_hi = 1'b1;
    i_wdata = 32'hDEAD_BEEF;
    start_op(MD_MULTU, 32'd2, 32'd3);
    i_wr_hi = 1'b0;
    wait_done();
    check("drop_hi", 64'(o_hi), 64'd0);
    check("drop_lo", 64'(o_lo), 64'd6);
    tick();

    // async reset mid-run
    start_op(MD_DIVU, 32'd1000, 32'd3);
    repeat (3) tick();
    i_rst = 1'b1;
    #1;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_hi", 64'(o_hi), 64'd0);
    check("midrst_lo", 64'(o_lo), 64'd0);
    #1;
    i_rst = 1'b0;
    i_wr_lo = 1'b1;
    i_wdata = 32'h0000_1234;
    tick();
    i_wr_lo = 1'b0;
    check("mtlo_lo", 64'(o_lo), 64'h1234);
    check("mtlo_hi", 64'(o_hi), 64'd0);
    i_wr_hi = 1'b1;
    i_wdata = 32'h0000_5678;
    tick();
    i_wr_hi = 1'b0;
    check("mthi_hi", 64'(o_hi), 64'h5678);
    check("mthi_lo", 64'(o_lo), 64'h1234);
    check("idle_busy", 64'(o_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
